lsp_to_az_pipe: RTL and testbench

- Converts one frame of 10 Q15 line spectral pairs (LSPs) into 11 Q12 LP filter coefficients a[0..10]. The conversion is bit-exact to the ITU G.729 Lsp_Az / Get_lsp_pol routines.
- The block bundles three things:
  - a 4096x32 scratch memory;
  - a control FSM with saturating 16/32-bit fixed-point arithmetic;
  - test-access muxes that let a host load inputs and read results.
- It is used in the encoder Int_LPC stage.

---
 rtl/lsp_to_az_pipe.sv | 226 ++++++++++++++++++++++
 tb/tb_lsp_to_az_pipe.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsp_to_az_pipe.sv
// LSP (Q15, 10 values) to LP coefficient (Q12, 11 values) converter with its own 4096x32 scratch memory.
// Latency: about 55 cycles from accepted start to done (11 load, 2x15 polynomial, 1 combine, 11 store).
// Backpressure: none; start is only sampled in IDLE, host test muxes bypass the FSM's memory port.
module lsp_to_az_pipe (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic [31:0] scratch_mem_in,
  input  logic [11:0] test_write_addr,
  input  logic        test_write_en,
  input  logic [31:0] test_write,
  input  logic [11:0] test_read_addr,
  input  logic        mem_Mux1Sel,
  input  logic        mem_Mux2Sel,
  input  logic        mem_Mux3Sel,
  input  logic        mem_Mux4Sel,
  input  logic [11:0] lsp_az_addr1,
  input  logic [11:0] lsp_az_addr2
);

  typedef enum logic [2:0] {IDLE, LOAD, POL1, POL2, COMBINE, STORE} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;          // LOAD / STORE slot index 0..10
  logic [2:0]  pi, pj;       // polynomial order i (1 = init) and inner index j
  logic [15:0] lsp_r [0:9];
  logic [31:0] f1 [0:5];
  logic [31:0] f2 [0:5];

  logic [31:0] mem [0:4095];
  logic        fsm_we;
  logic [11:0] fsm_waddr, fsm_raddr;
  logic [31:0] fsm_wdata;
  logic        mem_we;
  logic [11:0] mem_waddr, mem_raddr;
  logic [31:0] mem_wdata;

  logic        pol_odd;
  logic [15:0] q_cur;
  logic [31:0] q_x1024;
  logic [31:0] cur    [0:5];
  logic [31:0] cur_nx [0:5];
  logic [31:0] step_base, step_val;
  logic [2:0]  mirror;
  logic [15:0] a_val;

  // Saturating 32-bit add (L_add).
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) return s[32] ? 32'h8000_0000 : 32'h7fff_ffff;
    return s[31:0];
  endfunction

  // Saturating 32-bit subtract (L_sub).
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {a[31], a} - {b[31], b};
    if (s[32] != s[31]) return s[32] ? 32'h8000_0000 : 32'h7fff_ffff;
    return s[31:0];
  endfunction

  // Saturating left shift by one (L_shl by 1).
  function automatic logic [31:0] shl1_sat(input logic [31:0] x);
    if (x[31] != x[30]) return x[31] ? 32'h8000_0000 : 32'h7fff_ffff;
    return x << 1;
  endfunction

  // 32x16 DPF multiply: x split into hi / 15-bit lo halves.
  function automatic logic [31:0] mpy_32_16(input logic [31:0] x, input logic [15:0] q);
    logic signed [15:0] hi;
    logic signed [15:0] lo;
    logic signed [31:0] p_hi;
    logic signed [31:0] p_lo;
    logic [31:0]        l_hi;
    hi   = $signed(x[31:16]);
    lo   = $signed(16'((x >> 1) & 32'h0000_7fff));
    p_hi = hi * $signed(q);
    if (hi == 16'sh8000 && q == 16'h8000) l_hi = 32'h7fff_ffff;
    else                                  l_hi = 32'(p_hi <<< 1);
    p_lo = (lo * $signed(q)) >>> 15;
    return sat_add(l_hi, 32'(p_lo <<< 1));
  endfunction

  // Round Q24 to Q12 with carry-in at bit 12, keep the low 16 bits (wraps, no saturation).
  function automatic logic [15:0] rnd16(input logic [31:0] x);
    logic signed [32:0] t;
    t = $signed({x[31], x}) + 33'sd4096;
    return 16'(t >>> 13);
  endfunction

  // Memory port muxing: host test path or FSM; FSM writes are suppressed during reset.
  assign mem_waddr = mem_Mux1Sel ? test_write_addr : fsm_waddr;
  assign mem_wdata = mem_Mux2Sel ? test_write      : fsm_wdata;
  assign mem_we    = mem_Mux3Sel ? test_write_en   : (fsm_we & ~reset);
  assign mem_raddr = mem_Mux4Sel ? test_read_addr  : fsm_raddr;

  // Scratch memory: synchronous write, registered read, contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    scratch_mem_in <= mem[mem_raddr];
  end

  // Polynomial datapath: one init step, one inner recurrence step, or the f[1] update per cycle.
  always_comb begin
    pol_odd = (state == POL2);
    q_cur   = lsp_r[{pi - 3'd1, pol_odd}];
    q_x1024 = {{6{q_cur[15]}}, q_cur, 10'd0};
    for (int i = 0; i < 6; i++) cur[i] = pol_odd ? f2[i] : f1[i];
    for (int i = 0; i < 6; i++) cur_nx[i] = cur[i];
    // At j == i the fresh f[i] is a copy of f[i-2], so read that instead.
    step_base = (pj == pi) ? cur[pj - 3'd2] : cur[pj];
    step_val  = sat_sub(sat_add(step_base, cur[pj - 3'd2]),
                        shl1_sat(mpy_32_16(cur[pj - 3'd1], q_cur)));
    if (pi == 3'd1) begin
      cur_nx[0] = 32'h0100_0000;
      cur_nx[1] = sat_sub(32'd0, q_x1024);
    end else if (pj >= 3'd2) begin
      cur_nx[pj] = step_val;
    end else begin
      cur_nx[1] = sat_sub(cur[1], q_x1024);
    end
  end

  // Coefficient for the current store slot: a[0], sums for 1..5, differences mirrored for 6..10.
  always_comb begin
    mirror = 3'(4'd11 - cnt);
    if (cnt == 4'd0)       a_val = 16'h1000;
    else if (cnt <= 4'd5)  a_val = rnd16(sat_add(f1[cnt[2:0]], f2[cnt[2:0]]));
    else                   a_val = rnd16(sat_sub(f1[mirror], f2[mirror]));
  end

  // State register and done flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start)              done <= 1'b0;
      else if (state == STORE && cnt == 4'd10) done <= 1'b1;
    end
  end

  // Next state and FSM memory port drive.
  always_comb begin
    state_nx  = state;
    fsm_we    = 1'b0;
    fsm_waddr = 12'd0;
    fsm_wdata = 32'd0;
    fsm_raddr = 12'd0;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD: begin
        fsm_raddr = lsp_az_addr1 + {8'd0, cnt};
        if (cnt == 4'd10) state_nx = POL1;
      end
      POL1:    if (pi == 3'd5 && pj == 3'd1) state_nx = POL2;
      POL2:    if (pi == 3'd5 && pj == 3'd1) state_nx = COMBINE;
      COMBINE: state_nx = STORE;
      STORE: begin
        fsm_we    = 1'b1;
        fsm_waddr = lsp_az_addr2 + {8'd0, cnt};
        fsm_wdata = {{16{a_val[15]}}, a_val};
        if (cnt == 4'd10) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Sequencing counters, LSP capture and f1/f2 updates.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= 4'd0;
      pi  <= 3'd1;
      pj  <= 3'd2;
      for (int i = 0; i < 6; i++) begin
        f1[i] <= 32'd0;
        f2[i] <= 32'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          cnt <= 4'd0;
          pi  <= 3'd1;
          pj  <= 3'd2;
        end
        LOAD: begin
          // Read data lags the address by one cycle.
          if (cnt != 4'd0) lsp_r[cnt - 4'd1] <= scratch_mem_in[15:0];
          cnt <= (cnt == 4'd10) ? 4'd0 : cnt + 4'd1;
        end
        POL1, POL2: begin
          for (int i = 0; i < 6; i++) begin
            if (state == POL1) f1[i] <= cur_nx[i];
            else               f2[i] <= cur_nx[i];
          end
          if (pi == 3'd1) begin
            pi <= 3'd2;
            pj <= 3'd2;
          end else if (pj >= 3'd2) begin
            pj <= pj - 3'd1;
          end else if (pi == 3'd5) begin
            pi <= 3'd1;
            pj <= 3'd2;
          end else begin
            pi <= pi + 3'd1;
            pj <= pi + 3'd1;
          end
        end
        COMBINE: begin
          // Parallel update uses pre-update neighbours, matching the descending loop.
          for (int i = 1; i < 6; i++) begin
            f1[i] <= sat_add(f1[i], f1[i-1]);
            f2[i] <= sat_sub(f2[i], f2[i-1]);
          end
          cnt <= 4'd0;
        end
        STORE:   cnt <= cnt + 4'd1;
        default: cnt <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_lsp_to_az_pipe.sv
// Self-checking bench for lsp_to_az_pipe: host-path memory checks, pinned frames, start hold,
// mid-conversion reset and randomized frames against an arithmetic reference of the conversion.
module tb_lsp_to_az_pipe;

  logic        clock, reset, start, done;
  logic [31:0] scratch_mem_in;
  logic [11:0] test_write_addr, test_read_addr;
  logic        test_write_en;
  logic [31:0] test_write;
  logic        mem_Mux1Sel, mem_Mux2Sel, mem_Mux3Sel, mem_Mux4Sel;
  logic [11:0] lsp_az_addr1, lsp_az_addr2;

  lsp_to_az_pipe dut (
    .clock(clock), .reset(reset), .start(start), .done(done),
    .scratch_mem_in(scratch_mem_in),
    .test_write_addr(test_write_addr), .test_write_en(test_write_en),
    .test_write(test_write), .test_read_addr(test_read_addr),
    .mem_Mux1Sel(mem_Mux1Sel), .mem_Mux2Sel(mem_Mux2Sel),
    .mem_Mux3Sel(mem_Mux3Sel), .mem_Mux4Sel(mem_Mux4Sel),
    .lsp_az_addr1(lsp_az_addr1), .lsp_az_addr2(lsp_az_addr2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int done_rises = 0;

  logic [31:0] mem_model [4096];
  bit          written   [4096];
  logic [15:0] cur_lsp   [10];
  logic [31:0] exp_a     [11];
  logic [31:0] zero_tab  [11];
  logic [31:0] half_tab  [11];
  bit          rd_chk = 1'b0;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model (plain integer arithmetic) ----------------
  function automatic longint sat32(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic longint mpy(input longint x, input longint q);
    longint hi, lo, r;
    hi = x >>> 16;
    lo = (x >>> 1) & 64'h7fff;
    r  = sat32(2 * hi * q);
    r  = sat32(r + 2 * ((lo * q) >>> 15));
    return r;
  endfunction

  function automatic longint lsp_val(input int n);
    shortint s;
    s = shortint'(cur_lsp[n]);
    return longint'(s);
  endfunction

  function automatic logic [31:0] rnd_ext(input longint x);
    longint r;
    logic [15:0] l;
    r = (x + 4096) >>> 13;
    l = r[15:0];
    return {{16{l[15]}}, l};
  endfunction

  function automatic void model_az();
    longint f [2][6];
    longint q;
    for (int p = 0; p < 2; p++) begin
      f[p][0] = 64'sh0100_0000;
      f[p][1] = -lsp_val(p) * 1024;
      for (int i = 2; i <= 5; i++) begin
        q = lsp_val(2 * (i - 1) + p);
        f[p][i] = f[p][i-2];
        for (int j = i; j >= 2; j--)
          f[p][j] = sat32(sat32(f[p][j] + f[p][j-2]) - sat32(2 * mpy(f[p][j-1], q)));
        f[p][1] = sat32(f[p][1] - q * 1024);
      end
    end
    for (int i = 5; i >= 1; i--) begin
      f[0][i] = sat32(f[0][i] + f[0][i-1]);
      f[1][i] = sat32(f[1][i] - f[1][i-1]);
    end
    exp_a[0] = 32'h0000_1000;
    for (int i = 1; i <= 5; i++) begin
      exp_a[i]      = rnd_ext(sat32(f[0][i] + f[1][i]));
      exp_a[11 - i] = rnd_ext(sat32(f[0][i] - f[1][i]));
    end
  endfunction

  // ---------------- compare processes ----------------
  // Host reads: data registered at a posedge must equal the model memory at the captured address.
  initial begin
    logic [11:0] rd_q;
    bit          rd_v;
    forever begin
      @(posedge clock);
      rd_q = test_read_addr;
      rd_v = rd_chk && mem_Mux4Sel;
      @(negedge clock);
      if (rd_v && written[rd_q])
        check($sformatf("read[0x%03h]", rd_q), scratch_mem_in, mem_model[rd_q]);
    end
  end

  // Count rising edges of done.
  initial begin
    bit prev = 1'b0;
    forever begin
      @(negedge clock);
      if (done === 1'b1 && !prev) done_rises++;
      prev = (done === 1'b1);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- drivers ----------------
  task automatic host_write(input logic [11:0] ad, input logic [31:0] d);
    @(posedge clock); #1;
    mem_Mux1Sel = 1'b1; mem_Mux2Sel = 1'b1; mem_Mux3Sel = 1'b1;
    test_write_addr = ad; test_write = d; test_write_en = 1'b1;
    mem_model[ad] = d; written[ad] = 1'b1;
    @(posedge clock); #1;
    test_write_en = 1'b0;
  endtask

  task automatic read_sweep(input logic [11:0] base, input int n, input int dwell);
    @(posedge clock); #1;
    mem_Mux4Sel = 1'b1; rd_chk = 1'b1;
    for (int k = 0; k < n; k++) begin
      test_read_addr = base + 12'(k);
      repeat (dwell) begin @(posedge clock); #1; end
    end
    rd_chk = 1'b0; mem_Mux4Sel = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
  endtask

  task automatic write_lsps(input logic [11:0] b1);
    logic [31:0] w;
    for (int k = 0; k < 10; k++) begin
      w = $urandom;
      w[15:0] = cur_lsp[k];
      host_write(b1 + 12'(k), w);
    end
    @(posedge clock); #1;
    mem_Mux1Sel = 1'b0; mem_Mux2Sel = 1'b0; mem_Mux3Sel = 1'b0; mem_Mux4Sel = 1'b0;
  endtask

  task automatic run_frame(input int hold, input logic [11:0] b1, input logic [11:0] b2);
    int cyc, r0;
    bit got;
    write_lsps(b1);
    lsp_az_addr1 = b1; lsp_az_addr2 = b2;
    model_az();
    r0 = done_rises;
    start = 1'b1; cyc = 0;
    for (int h = 0; h < hold; h++) begin @(posedge clock); #1; cyc++; end
    start = 1'b0;
    got = done;
    while (!got && cyc < 400) begin @(posedge clock); #1; cyc++; got = done; end
    check("done_within_400", {31'd0, got}, 32'd1);
    @(negedge clock);
    check("done_pulses_per_frame", 32'(done_rises - r0), 32'd1);
    for (int k = 0; k < 11; k++) begin
      mem_model[b2 + 12'(k)] = exp_a[k];
      written[b2 + 12'(k)]   = 1'b1;
    end
    read_sweep(b2, 11, 1);
  endtask

  task automatic gen_lsp(input bit sorted);
    int v [10];
    int t;
    for (int k = 0; k < 10; k++)
      v[k] = sorted ? int'($urandom_range(64000)) - 32000 : int'($urandom_range(65535)) - 32768;
    if (sorted)
      for (int a = 0; a < 9; a++)
        for (int b = 0; b < 9 - a; b++)
          if (v[b] < v[b+1]) begin t = v[b]; v[b] = v[b+1]; v[b+1] = t; end
    for (int k = 0; k < 10; k++) cur_lsp[k] = 16'(v[k]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [11:0] b1, b2;
    int r0;
    zero_tab = '{32'h1000, 32'h0, 32'h5000, 32'h0, 32'hFFFFA000, 32'h0,
                 32'hFFFFA000, 32'h0, 32'h5000, 32'h0, 32'h1000};
    half_tab = '{32'h1000, 32'hFFFFF800, 32'h4800, 32'hFFFFE000, 32'hFFFF8000, 32'hFFFFD000,
                 32'h7000, 32'hFFFFE000, 32'h3000, 32'hFFFFF800, 32'h0800};
    for (int i = 0; i < 4096; i++) written[i] = 1'b0;
    reset = 1'b1; start = 1'b0;
    test_write_addr = '0; test_write_en = 1'b0; test_write = '0; test_read_addr = '0;
    mem_Mux1Sel = 1'b0; mem_Mux2Sel = 1'b0; mem_Mux3Sel = 1'b0; mem_Mux4Sel = 1'b0;
    lsp_az_addr1 = '0; lsp_az_addr2 = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Host path and reset preserving memory.
    host_write(12'h010, 32'h0000_1234);
    host_write(12'h011, 32'hCAFE_F00D);
    pulse_reset();
    check("done_after_reset", {31'd0, done}, 32'd0);
    read_sweep(12'h010, 2, 2);

    // Pinned frame: all-zero LSPs (exercises low16 wrap).
    for (int k = 0; k < 10; k++) cur_lsp[k] = 16'h0000;
    model_az();
    for (int k = 0; k < 11; k++) check($sformatf("model_zero_a%0d", k), exp_a[k], zero_tab[k]);
    run_frame(1, 12'h100, 12'h900);

    // Pinned frame: lsp[0]=0.5, others 0.
    cur_lsp[0] = 16'h4000;
    model_az();
    for (int k = 0; k < 11; k++) check($sformatf("model_half_a%0d", k), exp_a[k], half_tab[k]);
    run_frame(1, 12'h120, 12'h920);

    // Start held for 3 cycles: one conversion, done then stays high.
    gen_lsp(1'b1);
    r0 = done_rises;
    run_frame(3, 12'h200, 12'hA00);
    repeat (30) @(posedge clock);
    #1;
    check("done_holds_high", {31'd0, done}, 32'd1);
    check("single_conversion", 32'(done_rises - r0), 32'd1);

    // Reset mid-conversion: no writes afterwards, done low, then a clean rerun.
    gen_lsp(1'b1);
    b1 = 12'h300; b2 = 12'hB00;
    for (int k = 0; k < 11; k++) host_write(b2 + 12'(k), 32'h5A5A_0000 | 32'(k));
    write_lsps(b1);
    lsp_az_addr1 = b1; lsp_az_addr2 = b2;
    start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (20) @(posedge clock);
    pulse_reset();
    check("done_after_abort", {31'd0, done}, 32'd0);
    repeat (60) @(posedge clock);
    #1;
    check("idle_after_abort", {31'd0, done}, 32'd0);
    read_sweep(b2, 11, 1);
    run_frame(1, b1, b2);

    // Randomized back-to-back frames.
    for (int n = 0; n < 60; n++) begin
      gen_lsp((n % 4) != 3);
      b1 = 12'($urandom_range(2000));
      b2 = 12'($urandom_range(4084, 2048));
      run_frame(1, b1, b2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
